// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one line-wide memory port between I-cache and D-cache
module mem_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             proc_reset_n,
  input  logic             i_mem_read,
  input  logic [27:0]      i_mem_addr,
  output logic [127:0]     i_mem_rdata,
  output logic             i_mem_ready,
  input  logic             d_mem_read,
  input  logic             d_mem_write,
  input  logic [27:0]      d_mem_addr,
  input  logic [127:0]     d_mem_wdata,
  output logic [127:0]     d_mem_rdata,
  output logic             d_mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic [27:0]      mem_addr,
  output logic [127:0]     mem_wdata,
  input  logic [127:0]     mem_rdata,
  input  logic             mem_ready,
  output logic [CNT_W-1:0] i_cnt,
  output logic [CNT_W-1:0] d_cnt,
  output logic             proto_err
);
  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, GAP} state_t;
  state_t state;
  logic last_d;
  logic i_req, d_req, gi, gd;
  assign i_req = i_mem_read;
  assign d_req = d_mem_read | d_mem_write;
  assign gi = state == GRANT_I;
  assign gd = state == GRANT_D;
  assign i_mem_rdata = mem_rdata;
  assign d_mem_rdata = mem_rdata;
  // memory port mirrors the granted cache; a D write wins over a simultaneous D read
  always_comb begin
    mem_read    = gi ? i_mem_read : gd ? (d_mem_read & ~d_mem_write) : 1'b0;
    mem_write   = gd & d_mem_write;
    mem_addr    = gi ? i_mem_addr : gd ? d_mem_addr : '0;
    mem_wdata   = gd ? d_mem_wdata : '0;
    i_mem_ready = gi & mem_ready;
    d_mem_ready = gd & mem_ready;
  end
  // grant FSM with round-robin tie-break, saturating completion counters and sticky error
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state     <= IDLE;
      last_d    <= 1'b1;
      i_cnt     <= '0;
      d_cnt     <= '0;
      proto_err <= 1'b0;
    end else begin
      proto_err <= proto_err | (d_mem_read & d_mem_write);
      case (state)
        IDLE: begin
          if (i_req && d_req) state <= last_d ? GRANT_I : GRANT_D;
          else if (i_req)     state <= GRANT_I;
          else if (d_req)     state <= GRANT_D;
        end
        GRANT_I: begin
          if (mem_ready) begin
            state  <= GAP;
            last_d <= 1'b0;
            if (i_cnt != '1) i_cnt <= i_cnt + 1'b1;
          end else if (!i_req) state <= IDLE;
        end
        GRANT_D: begin
          if (mem_ready) begin
            state  <= GAP;
            last_d <= 1'b1;
            if (d_cnt != '1) d_cnt <= d_cnt + 1'b1;
          end else if (!d_req) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
